vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
VGA sink that sits on the far end of the hsync/vsync/rgb interface driven by the game's VGA controller. It locks to the incoming sync stream and recovers pixel coordinates and a data-enable. It also flags timing violations and produces a per-frame 16-bit pixel signature. Used as an on-chip loopback checker and as the bench monitor for the crossyroad display path.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width (informational; only the falling edge is checked)
H_TOTAL, 800, clocks per line
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive clean frames required for lock
SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low

Ports:
i_clk  in  1  pixel clock; same clock as the VGA generator
i_rst_n  in  1  asynchronous, active-low reset
i_hsync  in  1  horizontal sync, synchronous to i_clk
i_vsync  in  1  vertical sync, synchronous to i_clk
i_rgb  in  3  pixel colour {B,G,R}
o_hpos  out  10  recovered x of the pixel sampled on the previous edge
o_vpos  out  10  recovered y
o_rgb  out  3  registered i_rgb, aligned with o_hpos/o_vpos
o_de  out  1  locked && o_hpos<H_ACTIVE && o_vpos<V_ACTIVE
o_locked  out  1  timing lock
o_frame_start  out  1  1-cycle pulse when o_hpos=0, o_vpos=0 and locked
o_err_h  out  1  1-cycle pulse: hsync edge misplaced
o_err_v  out  1  1-cycle pulse: vsync edge misplaced
o_err_to  out  1  1-cycle pulse: hsync timeout
o_frame_sig  out  16  signature of the last complete locked frame
o_sig_valid  out  1  1-cycle pulse when o_frame_sig updates

Behaviour:
- Reset: i_rst_n low asynchronously clears every register. All outputs are 0, hc=vc=0, armed=0, good count=0.
- Sync normalisation: s_h and s_v are the sync inputs inverted when SYNC_ACTIVE_LOW=1. A fall is the sampled s_h (or s_v) going 1, with the previous sample 0. The previous-sample registers reset to 0.
- Latency: every output is registered. Outputs after edge t describe the inputs sampled at edge t.
- Counters, evaluated each cycle:
  - hc_n = (hc==H_TOTAL-1) ? 0 : hc+1
  - vc_n increments (wrapping at V_TOTAL-1) when hc wraps.
- Hsync fall:
  - expected hc_n == H_ACTIVE+H_FP (656).
  - On mismatch: pulse o_err_h and load hc = 656.
  - On match: hc_n is kept.
- Vsync fall:
  - expected hc_n==0 and vc_n==V_ACTIVE+V_FP (490).
  - On mismatch: pulse o_err_v and load vc = 490, hc = 0.
- Both falls in the same cycle: both checks apply. The vsync load of hc takes priority; both errors may pulse.
- Timeout:
  - A 12-bit counter clears on each hsync fall and saturates.
  - On reaching 2*H_TOTAL (1600), pulse o_err_to once. It pulses again only after a new hsync fall.
- Lock FSM, states UNLOCKED → ARMED → COUNTING → LOCKED:
  - Any error pulse returns the FSM to UNLOCKED with good=0, taking effect on the same edge.
  - UNLOCKED: the first clean vsync fall moves to ARMED.
  - Each clean vsync fall after that increments good.
  - good == LOCK_FRAMES sets o_locked on that edge (the 3rd clean vsync fall for default parameters).
- o_de and o_frame_start are forced 0 while unlocked.
- Signature accumulator:
  - On every cycle where the next o_de is 1: acc = rotl16(acc,1) ^ {13'b0, i_rgb}.
  - At each vsync fall, if the FSM was LOCKED before the edge and no error occurs that cycle: o_frame_sig = acc and o_sig_valid pulses.
  - acc clears to 0 at every vsync fall, whether or not o_frame_sig is updated.
- Reset mid-frame: same as power-up. Re-lock requires the full arming sequence again.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480 constants (active, porches, sync widths, totals). It is also used by the vga generator.
- One sub-module: frame_sig. It is the 16-bit rotate-xor accumulator with clear and capture inputs.
- Edge detect, counters, lock FSM and timeout stay in vga_sync_decoder.

Test Plan:
1. Reset, then a clean stream from the vga generator.
   - o_locked rises on the 3rd vsync fall.
   - o_hpos/o_vpos equal the generator's hpos/vpos delayed by 1 cycle.
   - No error pulses.
   - o_frame_start occurs once per 420000 cycles.
2. Locked, rgb=0 everywhere.
   - o_frame_sig=0x0000 with o_sig_valid once per frame.
   - Only pixel (0,0)=3'b001: o_frame_sig=0x8000 (307199 rotations ≡ rotr 1).
3. Hsync fall on line 100 delayed by 4 cycles.
   - o_err_h on that line and on the next line.
   - o_locked and o_de drop immediately.
   - Re-lock on the 3rd subsequent clean vsync fall.
4. Generator inserts an extra line, so vsync falls at line 491.
   - o_err_v pulses at that fall.
   - o_vpos reloads to 490.
   - o_sig_valid is not pulsed for that frame.
5. Hsync held inactive.
   - o_err_to pulses exactly 1600 cycles after the last hsync fall, once only.
   - o_locked goes 0.
6. i_rst_n pulsed low mid-frame (line 200).
   - All outputs go 0 asynchronously.
   - After release, behaviour matches scenario 1, including lock on the 3rd vsync fall.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and lock-FSM types shared by the VGA generator and sink.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = 800;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = 525;

    localparam int POS_W = 10;
    localparam int TO_W  = 12;
    localparam int SIG_W = 16;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_ARMED    = 2'd1,
        LK_COUNTING = 2'd2,
        LK_LOCKED   = 2'd3
    } lock_state_e;

    function automatic logic [SIG_W-1:0] rotl16(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], v[SIG_W-1]};
    endfunction

endpackage

// File: rtl/vga_sync_decoder_frame_sig.sv
// Per-frame pixel signature: rotate-left-by-one then xor the pixel colour on every
// enabled cycle; clear restarts the frame, capture publishes the finished value.
module frame_sig
    import vga_timing_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_capture,
    input  logic [2:0]       i_rgb,
    output logic [SIG_W-1:0] o_sig,
    output logic             o_valid
);

    logic [SIG_W-1:0] acc_q, acc_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             valid_q, valid_d;

    // Capture reads the pre-clear accumulator, so a frame end can publish and restart together.
    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = rotl16(acc_q) ^ {13'b0, i_rgb};
        end
        sig_d   = i_capture ? acc_q : sig_q;
        valid_d = i_capture;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            sig_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sig_q   <= sig_d;
            valid_q <= valid_d;
        end
    end

    assign o_sig   = sig_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sink: locks onto hsync/vsync, recovers pixel coordinates and data-enable,
// flags misplaced sync edges and hsync timeouts, and signs each locked frame.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int LOCK_FRAMES     = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [2:0]  i_rgb,
    output logic [9:0]  o_hpos,
    output logic [9:0]  o_vpos,
    output logic [2:0]  o_rgb,
    output logic        o_de,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_err_h,
    output logic        o_err_v,
    output logic        o_err_to,
    output logic [15:0] o_frame_sig,
    output logic        o_sig_valid
);

    localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_FALL_POS = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] V_FALL_POS = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] H_ACT      = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT      = POS_W'(V_ACTIVE);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(2 * H_TOTAL);
    localparam logic [3:0]       GOOD_GOAL  = 4'(LOCK_FRAMES);

    lock_state_e      state_q, state_d;
    logic [3:0]       good_q, good_d;
    logic [POS_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [POS_W-1:0] hc_inc, vc_inc;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             h_prev_q, v_prev_q;
    logic [2:0]       rgb_q;
    logic             locked_q, locked_d;
    logic             de_q, de_d;
    logic             fs_q, fs_d;
    logic             err_h_q, err_h_d;
    logic             err_v_q, err_v_d;
    logic             err_to_q, err_to_d;
    logic             s_h, s_v, h_fall, v_fall, err_any, sig_capture;

    assign s_h    = SYNC_ACTIVE_LOW ? ~i_hsync : i_hsync;
    assign s_v    = SYNC_ACTIVE_LOW ? ~i_vsync : i_vsync;
    assign h_fall = s_h & ~h_prev_q;
    assign v_fall = s_v & ~v_prev_q;

    // Free-running position with resync loads; the vsync load of hc wins over the hsync load.
    always_comb begin
        hc_inc = (hc_q == H_LAST) ? '0 : hc_q + POS_W'(1);
        vc_inc = vc_q;
        if (hc_q == H_LAST) begin
            vc_inc = (vc_q == V_LAST) ? '0 : vc_q + POS_W'(1);
        end
        err_h_d = h_fall && (hc_inc != H_FALL_POS);
        err_v_d = v_fall && ((hc_inc != '0) || (vc_inc != V_FALL_POS));
        hc_d = hc_inc;
        vc_d = vc_inc;
        if (err_h_d) begin
            hc_d = H_FALL_POS;
        end
        if (err_v_d) begin
            hc_d = '0;
            vc_d = V_FALL_POS;
        end
        to_cnt_d = h_fall ? '0 : ((to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1));
        err_to_d = !h_fall && (to_cnt_q != '1) && (to_cnt_q + TO_W'(1) == TO_LIMIT);
    end

    assign err_any = err_h_d | err_v_d | err_to_d;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (err_any) begin
            state_d = LK_UNLOCKED;
            good_d  = '0;
        end else if (v_fall) begin
            case (state_q)
                LK_UNLOCKED: state_d = LK_ARMED;
                LK_ARMED, LK_COUNTING: begin
                    good_d  = good_q + 4'd1;
                    state_d = (good_d == GOOD_GOAL) ? LK_LOCKED : LK_COUNTING;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        locked_d    = (state_d == LK_LOCKED);
        de_d        = locked_d && (hc_d < H_ACT) && (vc_d < V_ACT);
        fs_d        = locked_d && (hc_d == '0) && (vc_d == '0);
        sig_capture = v_fall && !err_any && (state_q == LK_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= LK_UNLOCKED;
            good_q   <= '0;
            hc_q     <= '0;
            vc_q     <= '0;
            to_cnt_q <= '0;
            h_prev_q <= 1'b0;
            v_prev_q <= 1'b0;
            rgb_q    <= '0;
            locked_q <= 1'b0;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
            err_h_q  <= 1'b0;
            err_v_q  <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            to_cnt_q <= to_cnt_d;
            h_prev_q <= s_h;
            v_prev_q <= s_v;
            rgb_q    <= i_rgb;
            locked_q <= locked_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
            err_h_q  <= err_h_d;
            err_v_q  <= err_v_d;
            err_to_q <= err_to_d;
        end
    end

    frame_sig u_frame_sig (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (de_d),
        .i_clear   (v_fall),
        .i_capture (sig_capture),
        .i_rgb     (i_rgb),
        .o_sig     (o_frame_sig),
        .o_valid   (o_sig_valid)
    );

    assign o_hpos        = hc_q;
    assign o_vpos        = vc_q;
    assign o_rgb         = rgb_q;
    assign o_de          = de_q;
    assign o_locked      = locked_q;
    assign o_frame_start = fs_q;
    assign o_err_h       = err_h_q;
    assign o_err_v       = err_v_q;
    assign o_err_to      = err_to_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken 8x6 raster (16x10 total) so
// whole frames, lock sequences and timeouts fit in a few thousand cycles.
module tb_vga_sync_decoder;

    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HT  = 16;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VT  = 10;
    localparam int HS0 = HA + HF;
    localparam int VS0 = VA + VF;
    localparam int FRAME = HT * VT;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_hsync = 1'b1;
    logic        i_vsync = 1'b1;
    logic [2:0]  i_rgb = 3'd0;
    logic [9:0]  o_hpos, o_vpos;
    logic [2:0]  o_rgb;
    logic        o_de, o_locked, o_frame_start, o_err_h, o_err_v, o_err_to, o_sig_valid;
    logic [15:0] o_frame_sig;

    always #5 i_clk = ~i_clk;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VF), .V_TOTAL(VT),
        .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_rgb(i_rgb),
        .o_hpos(o_hpos), .o_vpos(o_vpos), .o_rgb(o_rgb), .o_de(o_de), .o_locked(o_locked),
        .o_frame_start(o_frame_start), .o_err_h(o_err_h), .o_err_v(o_err_v), .o_err_to(o_err_to),
        .o_frame_sig(o_frame_sig), .o_sig_valid(o_sig_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // generator state
    int   gen_h = 0, gen_v = 0, gen_vt = VT, gen_vs0 = VS0, skew_line = -1;
    logic hs_off = 1'b0, single = 1'b0;
    int   px = 0, py = 0;
    logic [2:0] pv = 3'd0;

    // observation state
    int   cyc = 0;
    logic prev_hs = 1'b0, prev_vs = 1'b0, prev_locked = 1'b0;
    int   vfalls, lock_at, n_err_h, n_err_v, n_err_to, n_fs, n_sv;
    int   fs_last, fs_prev, to_cyc, hfall_cyc, track_bad;
    logic track, lock_on_fall, errh_first, errh_locked, to_locked;
    logic fall_err_v, fall_sigv;
    logic [9:0]  fall_vpos, fall_hpos;
    logic [15:0] last_sig;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_hpos"},   16'(o_hpos), 16'd0);
        chk({p, "_vpos"},   16'(o_vpos), 16'd0);
        chk({p, "_rgb"},    16'(o_rgb), 16'd0);
        chk({p, "_de"},     16'(o_de), 16'd0);
        chk({p, "_locked"}, 16'(o_locked), 16'd0);
        chk({p, "_fs"},     16'(o_frame_start), 16'd0);
        chk({p, "_err_h"},  16'(o_err_h), 16'd0);
        chk({p, "_err_v"},  16'(o_err_v), 16'd0);
        chk({p, "_err_to"}, 16'(o_err_to), 16'd0);
        chk({p, "_sig"},    o_frame_sig, 16'd0);
        chk({p, "_sigv"},   16'(o_sig_valid), 16'd0);
    endtask

    task automatic clear_obs();
        vfalls = 0; lock_at = -1; n_err_h = 0; n_err_v = 0; n_err_to = 0;
        n_fs = 0; n_sv = 0; fs_last = 0; fs_prev = 0; to_cyc = 0; track_bad = 0;
        track = 1'b0; lock_on_fall = 1'b0; errh_first = 1'b1; errh_locked = 1'b1;
        to_locked = 1'b1; fall_err_v = 1'b0; fall_sigv = 1'b1; fall_vpos = '1; fall_hpos = '1;
    endtask

    task automatic tick();
        logic hs_act, vs_act, h_fall, v_fall;
        int   hs0;
        hs0    = (gen_v == skew_line) ? HS0 + 4 : HS0;
        hs_act = !hs_off && (gen_h >= hs0) && (gen_h < hs0 + 2);
        vs_act = (gen_v >= gen_vs0) && (gen_v < gen_vs0 + 2);
        i_hsync = ~hs_act;
        i_vsync = ~vs_act;
        i_rgb   = (single && gen_h == px && gen_v == py) ? pv : 3'd0;
        @(posedge i_clk);
        #1;
        cyc++;
        h_fall  = hs_act && !prev_hs;
        v_fall  = vs_act && !prev_vs;
        prev_hs = hs_act;
        prev_vs = vs_act;
        if (h_fall) hfall_cyc = cyc;
        if (i_rst_n) begin
            if (v_fall) begin
                vfalls++;
                fall_err_v = o_err_v;
                fall_vpos  = o_vpos;
                fall_hpos  = o_hpos;
                fall_sigv  = o_sig_valid;
            end
            if (o_locked && !prev_locked) begin
                lock_at      = vfalls;
                lock_on_fall = v_fall;
            end
            if (o_err_h) begin
                n_err_h++;
                if (errh_first) begin
                    errh_locked = o_locked;
                    errh_first  = 1'b0;
                end
            end
            if (o_err_v) n_err_v++;
            if (o_err_to) begin
                n_err_to++;
                to_cyc    = cyc;
                to_locked = o_locked;
            end
            if (o_frame_start) begin
                n_fs++;
                fs_prev = fs_last;
                fs_last = cyc;
            end
            if (o_sig_valid) begin
                n_sv++;
                last_sig = o_frame_sig;
            end
            if (track && (o_hpos !== 10'(gen_h) || o_vpos !== 10'(gen_v) || o_rgb !== i_rgb ||
                          o_de !== (gen_h < HA && gen_v < VA)))
                track_bad++;
        end
        prev_locked = o_locked;
        gen_h++;
        if (gen_h == HT) begin
            gen_h = 0;
            gen_v++;
            if (gen_v == gen_vt) gen_v = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic sig_case(input string tag, input int x, input int y, input logic [2:0] v,
                            input logic [15:0] exp);
        single = 1'b1; px = x; py = y; pv = v;
        n_sv = 0;
        run(FRAME);
        chk({tag, "_count"}, 16'(n_sv), 16'd1);
        chk({tag, "_value"}, last_sig, exp);
    endtask

    initial begin
        last_sig = '0;
        hfall_cyc = 0;
        clear_obs();

        // power-up reset
        repeat (3) @(posedge i_clk);
        #1;
        chk_zero("reset");
        i_rst_n = 1'b1;

        // 1: clean stream, lock on the third vsync fall, then two locked frames
        run(3 * FRAME);
        chk("lock_fall_no", 16'(lock_at), 16'd3);
        chk("lock_on_fall_edge", 16'(lock_on_fall), 16'd1);
        clear_obs();
        track = 1'b1;
        run(2 * FRAME);
        chk("track_pos_de_rgb", 16'(track_bad), 16'd0);
        chk("clean_err_h", 16'(n_err_h), 16'd0);
        chk("clean_err_v", 16'(n_err_v), 16'd0);
        chk("clean_err_to", 16'(n_err_to), 16'd0);
        chk("fs_count", 16'(n_fs), 16'd2);
        chk("fs_period", 16'(fs_last - fs_prev), 16'(FRAME));

        // 2: signatures; rgb was 0 for the frames above
        chk("sig_zero_count", 16'(n_sv), 16'd2);
        chk("sig_zero_value", last_sig, 16'h0000);
        sig_case("sig_first_px", 0, 0, 3'b001, 16'h8000);
        sig_case("sig_last_px", HA - 1, VA - 1, 3'b101, 16'h0005);
        sig_case("sig_second_px", 1, 0, 3'b100, 16'h0001);
        single = 1'b0;

        // 3: hsync fall on line 2 delayed by 4 clocks
        clear_obs();
        skew_line = 2;
        run(FRAME);
        skew_line = -1;
        run(2 * FRAME);
        chk("skew_err_h", 16'(n_err_h), 16'd2);
        chk("skew_locked_drop", 16'(errh_locked), 16'd0);
        chk("skew_err_v", 16'(n_err_v), 16'd0);
        chk("skew_relock_fall", 16'(lock_at), 16'd3);
        chk("skew_locked_end", 16'(o_locked), 16'd1);

        // 4: one frame with an extra line before vsync
        clear_obs();
        gen_vt = VT + 1; gen_vs0 = VS0 + 1;
        run(HT * (VT + 1));
        gen_vt = VT; gen_vs0 = VS0;
        chk("xline_err_v_count", 16'(n_err_v), 16'd1);
        chk("xline_err_v_at_fall", 16'(fall_err_v), 16'd1);
        chk("xline_vpos_reload", 16'(fall_vpos), 16'(VS0));
        chk("xline_hpos_reload", 16'(fall_hpos), 16'd0);
        chk("xline_no_sig_at_fall", 16'(fall_sigv), 16'd0);
        chk("xline_no_sig", 16'(n_sv), 16'd0);
        chk("xline_err_h", 16'(n_err_h), 16'd0);
        chk("xline_unlocked", 16'(o_locked), 16'd0);
        clear_obs();
        run(3 * FRAME);
        chk("xline_relock_fall", 16'(lock_at), 16'd3);
        clear_obs();
        track = 1'b1;
        run(FRAME);
        chk("xline_track", 16'(track_bad), 16'd0);

        // 5: hsync held inactive for a frame
        clear_obs();
        hs_off = 1'b1;
        run(FRAME);
        hs_off = 1'b0;
        chk("to_count", 16'(n_err_to), 16'd1);
        chk("to_delay", 16'(to_cyc - hfall_cyc), 16'(2 * HT));
        chk("to_locked_drop", 16'(to_locked), 16'd0);
        chk("to_unlocked_end", 16'(o_locked), 16'd0);
        chk("to_no_err_h", 16'(n_err_h), 16'd0);
        chk("to_no_err_v", 16'(n_err_v), 16'd0);

        // relock with a non-zero signature before the mid-frame reset
        single = 1'b1; px = 0; py = 0; pv = 3'b001;
        run(3 * FRAME);
        chk("pre_rst_locked", 16'(o_locked), 16'd1);
        chk("pre_rst_sig", o_frame_sig, 16'h8000);

        // 6: asynchronous reset on line 2, released at the next frame start
        run(2 * HT + 5);
        chk("pre_rst_hpos", 16'(o_hpos), 16'd4);
        i_rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        while (!(gen_h == 0 && gen_v == 0)) tick();
        i_rst_n = 1'b1;
        clear_obs();
        run(3 * FRAME);
        chk("rst_relock_fall", 16'(lock_at), 16'd3);
        clear_obs();
        track = 1'b1;
        run(FRAME);
        chk("rst_track", 16'(track_bad), 16'd0);
        chk("rst_err_h", 16'(n_err_h), 16'd0);
        chk("rst_err_v", 16'(n_err_v), 16'd0);
        chk("rst_fs_count", 16'(n_fs), 16'd1);
        chk("rst_sig_count", 16'(n_sv), 16'd1);
        chk("rst_sig_value", last_sig, 16'h8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
